// File: rtl/ram_wb_if.sv
// Wishbone classic slave bus bundle for the ram_wb memory.
// The master modport is the bus side, the slave modport is the memory side.
interface ram_wb_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o
    );
endinterface

// File: rtl/ram_wb.sv
// Parametrised Wishbone classic slave memory with byte-lane writes, programmable
// wait states, error response for out-of-range or refused writes, and cycle abort.
module ram_wb #(
    parameter     MEM_IMAGE   = "",
    parameter int DEPTH       = 3072,
    parameter int WAIT_STATES = 0,
    parameter bit READ_ONLY   = 1'b0
) (
    input logic     clk,
    input logic     resetn,
    ram_wb_if.slave wbs
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] idx_q;
    logic          we_q;
    logic          err_q;
    logic [3:0]    sel_q;
    logic [31:0]   dat_q;
    logic [31:0]   mem [DEPTH];

    logic          req;
    logic [AW-1:0] idx_in;
    logic          mem_wr;

    assign req    = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign idx_in = wbs.wbs_adr_i[AW+1:2];
    assign mem_wr = (state == RESP) && !err_q && we_q;

    wire unused_adr = ^{wbs.wbs_adr_i[31:AW+2], wbs.wbs_adr_i[1:0]};

    // The transfer happens on the edge leaving RESP, so the registered ack/err is
    // visible in the following cycle while the FSM is already able to accept again.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            idx_q         <= '0;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
            sel_q         <= '0;
            dat_q         <= '0;
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_err_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
        end else begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q <= idx_in;
                        we_q  <= wbs.wbs_we_i;
                        sel_q <= wbs.wbs_sel_i;
                        dat_q <= wbs.wbs_dat_i;
                        err_q <= ({1'b0, idx_in} >= DEPTH_W) | (wbs.wbs_we_i & READ_ONLY);
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            wait_cnt <= 4'(WAIT_STATES - 1);
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (err_q) begin
                        wbs.wbs_err_o <= 1'b1;
                    end else begin
                        wbs.wbs_ack_o <= 1'b1;
                        if (!we_q) begin
                            wbs.wbs_dat_o <= mem[idx_q];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage kept free of reset so it maps onto a single-port block RAM.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_wb.sv
// Self-checking bench for ram_wb: three instances (no wait states, three wait
// states, read-only) driven through one shared master and checked against a word-array model.
module tb_ram_wb;
    logic        clk;
    logic        resetn;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    int          dsel;

    logic        ack_mux, err_mux;
    logic [31:0] dat_mux;

    int total;
    int bad;

    logic [31:0] model_mem [0:2][0:3071];
    logic [31:0] last_dat  [0:2];

    ram_wb_if if0 ();
    ram_wb_if if3 ();
    ram_wb_if ifr ();

    ram_wb #(.DEPTH(3072), .WAIT_STATES(0), .READ_ONLY(1'b0)) dut0 (.clk(clk), .resetn(resetn), .wbs(if0));
    ram_wb #(.DEPTH(3072), .WAIT_STATES(3), .READ_ONLY(1'b0)) dut3 (.clk(clk), .resetn(resetn), .wbs(if3));
    ram_wb #(.DEPTH(3072), .WAIT_STATES(0), .READ_ONLY(1'b1)) dutr (.clk(clk), .resetn(resetn), .wbs(ifr));

    assign if0.wbs_cyc_i = cyc & (dsel == 0);
    assign if0.wbs_stb_i = stb;
    assign if0.wbs_we_i  = we;
    assign if0.wbs_sel_i = sel;
    assign if0.wbs_adr_i = adr;
    assign if0.wbs_dat_i = dat;
    assign if3.wbs_cyc_i = cyc & (dsel == 1);
    assign if3.wbs_stb_i = stb;
    assign if3.wbs_we_i  = we;
    assign if3.wbs_sel_i = sel;
    assign if3.wbs_adr_i = adr;
    assign if3.wbs_dat_i = dat;
    assign ifr.wbs_cyc_i = cyc & (dsel == 2);
    assign ifr.wbs_stb_i = stb;
    assign ifr.wbs_we_i  = we;
    assign ifr.wbs_sel_i = sel;
    assign ifr.wbs_adr_i = adr;
    assign ifr.wbs_dat_i = dat;

    always_comb begin
        ack_mux = if0.wbs_ack_o;
        err_mux = if0.wbs_err_o;
        dat_mux = if0.wbs_dat_o;
        if (dsel == 1) begin
            ack_mux = if3.wbs_ack_o;
            err_mux = if3.wbs_err_o;
            dat_mux = if3.wbs_dat_o;
        end else if (dsel == 2) begin
            ack_mux = ifr.wbs_ack_o;
            err_mux = ifr.wbs_err_o;
            dat_mux = ifr.wbs_dat_o;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // One complete transfer; 'learn' adopts the read data of a word whose contents are unknown.
    task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] s,
                                 input string tag, input bit learn);
        int          lat;
        int          idx;
        int          exp_lat;
        logic        got_ack, got_err, exp_err;
        logic [31:0] rdat, exp_dat;

        idx     = int'(a[13:2]);
        exp_err = (idx >= 3072) || (w && d == 2);
        exp_lat = (d == 1) ? 5 : 2;
        exp_dat = last_dat[d];
        if (!exp_err && !w) exp_dat = model_mem[d][idx];

        @(negedge clk);
        dsel = d; we = w; adr = a; dat = wd; sel = s; cyc = 1'b1; stb = 1'b1;
        lat = 0; got_ack = 1'b0; got_err = 1'b0; rdat = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack_mux || err_mux) begin
                got_ack = ack_mux;
                got_err = err_mux;
                rdat    = dat_mux;
                break;
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;

        if (learn && !exp_err && !w) begin
            model_mem[d][idx] = rdat;
            exp_dat = rdat;
        end
        checkOutput({tag, "_ack"}, 32'(got_ack), 32'(!exp_err));
        checkOutput({tag, "_err"}, 32'(got_err), 32'(exp_err));
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_dat"}, rdat, exp_dat);
        @(posedge clk); #1;
        checkOutput({tag, "_idle"}, {30'b0, ack_mux, err_mux}, 32'h0);

        if (!exp_err) begin
            if (w) model_mem[d][idx] = mergeBytes(model_mem[d][idx], wd, s);
            else   last_dat[d] = exp_dat;
        end
    endtask

    initial begin
        logic [31:0] word, rnd, pre;
        logic [31:0] bb_adr [4];
        bit          saw_resp;

        total = 0; bad = 0;
        dsel = 0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0;
        for (int d = 0; d < 3; d++) last_dat[d] = '0;
        resetn = 1'b0;

        #2;
        checkOutput("rst_ack0", 32'(if0.wbs_ack_o), 32'h0);
        checkOutput("rst_err0", 32'(if0.wbs_err_o), 32'h0);
        checkOutput("rst_dat0", if0.wbs_dat_o, 32'h0);
        checkOutput("rst_dat3", if3.wbs_dat_o, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        $display("[TB] reset released");

        for (int wi = 0; wi < 32; wi++) begin
            rnd = $urandom;
            if (wi == 5) rnd = 32'hDEADBEEF;
            if (wi == 8) rnd = 32'hAABBCCDD;
            applyStimulus(0, 1'b1, 32'(wi) << 2, rnd, 4'hF, "pre0", 1'b0);
            applyStimulus(1, 1'b1, 32'(wi) << 2, rnd, 4'hF, "pre3", 1'b0);
        end

        applyStimulus(0, 1'b0, 32'h14, 32'h0, 4'hF, "rd14", 1'b0);
        checkOutput("rd14_const", last_dat[0], 32'hDEADBEEF);

        applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'b0101, "wr20", 1'b0);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'hF, "rb20", 1'b0);
        checkOutput("rb20_const", last_dat[0], 32'hAA22CC44);

        applyStimulus(0, 1'b1, 32'h28, 32'h55667788, 4'b0000, "wrsel0", 1'b0);
        applyStimulus(0, 1'b0, 32'h28, 32'h0, 4'hF, "rbsel0", 1'b0);

        applyStimulus(1, 1'b0, 32'h14, 32'h0, 4'hF, "ws3rd", 1'b0);
        checkOutput("ws3rd_const", last_dat[1], 32'hDEADBEEF);

        // Random mix with aliased upper/low address bits; writes avoid words 0..9.
        for (int it = 0; it < 40; it++) begin
            int d;
            d    = $urandom_range(0, 1);
            rnd  = $urandom;
            word = 32'($urandom_range(0, 31));
            adr  = ($urandom & 32'hFFFF_C000) | (word << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1 && word >= 10)
                applyStimulus(d, 1'b1, adr, rnd, 4'($urandom_range(0, 15)), "rndwr", 1'b0);
            else
                applyStimulus(d, 1'b0, adr, 32'h0, 4'hF, "rndrd", 1'b0);
            if (it % 8 == 7) begin
                word = 32'($urandom_range(3072, 4095));
                applyStimulus(d, 1'($urandom_range(0, 1)), word << 2, rnd, 4'hF, "rndoor", 1'b0);
            end
        end

        applyStimulus(0, 1'b0, 32'h14, 32'h0, 4'hF, "pre_oor", 1'b0);
        applyStimulus(0, 1'b0, 32'h3000, 32'h0, 4'hF, "oor3000", 1'b0);
        checkOutput("oor3000_keep", if0.wbs_dat_o, 32'hDEADBEEF);

        // Abort a write on the wait-state instance during its second wait cycle.
        @(negedge clk);
        dsel = 1; we = 1'b1; adr = 32'h24; dat = 32'hCAFEF00D; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        saw_resp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack_mux || err_mux) saw_resp = 1'b1;
        end
        checkOutput("abort_noresp", 32'(saw_resp), 32'h0);
        applyStimulus(1, 1'b0, 32'h24, 32'h0, 4'hF, "abort_rb", 1'b0);

        applyStimulus(2, 1'b0, 32'h0, 32'h0, 4'hF, "ro_rd0", 1'b1);
        pre = last_dat[2];
        applyStimulus(2, 1'b1, 32'h0, ~pre, 4'hF, "ro_wr0", 1'b0);
        applyStimulus(2, 1'b0, 32'h0, 32'h0, 4'hF, "ro_rb0", 1'b0);
        applyStimulus(2, 1'b0, 32'h3004, 32'h0, 4'hF, "ro_oor", 1'b0);

        // Asynchronous reset in the middle of a waited write.
        applyStimulus(1, 1'b0, 32'h14, 32'h0, 4'hF, "prerst", 1'b0);
        @(negedge clk);
        dsel = 1; we = 1'b1; adr = 32'h14; dat = 32'h0BADC0DE; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checkOutput("arst_ack", 32'(ack_mux), 32'h0);
        checkOutput("arst_err", 32'(err_mux), 32'h0);
        checkOutput("arst_dat3", if3.wbs_dat_o, 32'h0);
        checkOutput("arst_dat0", if0.wbs_dat_o, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        for (int d = 0; d < 3; d++) last_dat[d] = '0;
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1, 1'b0, 32'h14, 32'h0, 4'hF, "arst_rb", 1'b0);
        checkOutput("arst_rb_const", last_dat[1], 32'hDEADBEEF);

        // Request held continuously: acceptance every other edge, data of the accepted address.
        for (int k = 0; k < 4; k++) bb_adr[k] = 32'($urandom_range(0, 31)) << 2;
        @(negedge clk);
        dsel = 0; we = 1'b0; sel = 4'hF; adr = bb_adr[0]; cyc = 1'b1; stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checkOutput("b2b_gap", 32'(ack_mux), 32'h0);
            @(negedge clk);
            if (k < 3) adr = bb_adr[k+1];
            @(posedge clk); #1;
            checkOutput("b2b_ack", 32'(ack_mux), 32'h1);
            checkOutput("b2b_dat", dat_mux, model_mem[0][bb_adr[k][13:2]]);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        checkOutput("b2b_end", 32'(ack_mux), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
